// File: rtl/lc3_wb_regfile_p.sv
// lc3_wb_regfile_p: LC-3 writeback stage feeding a register file.
//
// A writeback request (wb_valid/wb_ready) is captured into a one-entry stage
// register. On the following edge it is written into the register array, and
// the N/Z/P condition code is updated. After reset, the array is cleared one
// register per cycle (busy high). Requests are only accepted after the clear
// sequence has finished.
//
// Handshake: a request transfers on a rising edge where wb_valid and wb_ready
// are both high. wb_ready depends only on the FSM state and never on wb_valid.
// The source may change its request freely while wb_ready is low.
//
// Optional feature: define LC3_WB_BYPASS_EN to forward pending stage data to
// the read ports. Without it, the read ports show the array contents only.
//
// fsm_state is a debug view of the FSM: 0 = CLEAR, 1 = RUN.
module lc3_wb_regfile_p #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [1:0]        w_control,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] memout,
    input  logic [DATA_W-1:0] pcout,
    input  logic [DATA_W-1:0] npc,
    input  logic [AW-1:0]     dr,
    input  logic [AW-1:0]     sr1,
    input  logic [AW-1:0]     sr2,
    output logic [DATA_W-1:0] d1,
    output logic [DATA_W-1:0] d2,
    output logic [2:0]        psr,
    output logic              busy,
    output logic              wb_pending,
    output logic              fsm_state
);

    localparam logic [0:0]    CLEAR    = 1'b0;
    localparam logic [0:0]    RUN      = 1'b1;
    localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

    logic [0:0]        state;
    logic [AW-1:0]     clr_cnt;
    logic [DATA_W-1:0] regs [NREG];
    logic [AW-1:0]     stage_dr;
    logic [DATA_W-1:0] stage_data;
    logic [DATA_W-1:0] wb_sel;
    logic [2:0]        next_psr;
    logic              accept;

    assign wb_ready  = (state == RUN);
    assign busy      = (state == CLEAR);
    assign accept    = wb_valid && wb_ready;
    assign fsm_state = state;

    // Clear sequencer: walk clr_cnt over every register, then enter RUN for good.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + AW'(1);
            if (clr_cnt == LAST_REG) begin
                state <= RUN;
            end
        end
    end

    // Writeback source mux selected by w_control.
    always_comb begin
        wb_sel = aluout;
        case (w_control)
            2'd0:    wb_sel = aluout;
            2'd1:    wb_sel = memout;
            2'd2:    wb_sel = pcout;
            default: wb_sel = npc;
        endcase
    end

    // Pending flag: set by an accepted request, otherwise drops after the write edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_pending <= 1'b0;
        end else begin
            wb_pending <= accept;
        end
    end

    // Stage payload: only meaningful while wb_pending is high, so no reset needed.
    always_ff @(posedge clock) begin
        if (accept) begin
            stage_dr   <= dr;
            stage_data <= wb_sel;
        end
    end

    // Register array: clear writes during CLEAR, staged writeback during RUN.
    // Reset blocks all writes, which discards any pending writeback.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) begin
                regs[clr_cnt] <= '0;
            end else if (wb_pending) begin
                regs[stage_dr] <= stage_data;
            end
        end
    end

    // Condition code of the value being written: negative, zero or positive.
    always_comb begin
        next_psr = 3'b001;
        if (stage_data[DATA_W-1]) begin
            next_psr = 3'b100;
        end else if (stage_data == '0) begin
            next_psr = 3'b010;
        end
    end

    // psr follows each performed writeback and holds otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            psr <= 3'b010;
        end else if (state == RUN && wb_pending) begin
            psr <= next_psr;
        end
    end

`ifdef LC3_WB_BYPASS_EN
    // Read ports with forwarding from the stage register on an address match.
    always_comb begin
        d1 = regs[sr1];
        d2 = regs[sr2];
        if (wb_pending && sr1 == stage_dr) begin
            d1 = stage_data;
        end
        if (wb_pending && sr2 == stage_dr) begin
            d2 = stage_data;
        end
    end
`else
    // Read ports straight from the array; a write shows up after its edge.
    always_comb begin
        d1 = regs[sr1];
        d2 = regs[sr2];
    end
`endif

endmodule

// File: tb/tb_lc3_wb_regfile_p.sv
// Bench for lc3_wb_regfile_p: directed scenarios plus randomized traffic,
// checked against a register-file reference model with a queue of pending
// writebacks. A second instance covers the 32-bit / 16-register build.
module tb_lc3_wb_regfile_p;

    localparam int DW  = 16;
    localparam int NR  = 8;
    localparam int AW  = 3;
    localparam int DW2 = 32;
    localparam int NR2 = 16;
    localparam int AW2 = 4;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- main instance signals ----------------
    logic          wb_valid;
    logic [1:0]    w_control;
    logic [DW-1:0] aluout, memout, pcout, npc;
    logic [AW-1:0] dr, sr1, sr2;
    logic          wb_ready, busy, wb_pending, fsm_state;
    logic [DW-1:0] d1, d2;
    logic [2:0]    psr;

    // ---------------- wide instance signals ----------------
    logic           w2_valid;
    logic [1:0]     w2_control;
    logic [DW2-1:0] w2_alu, w2_mem, w2_pc, w2_npc;
    logic [AW2-1:0] w2_dr, w2_sr1, w2_sr2;
    logic           w2_ready, w2_busy, w2_pending, w2_state;
    logic [DW2-1:0] w2_d1, w2_d2;
    logic [2:0]     w2_psr;

    lc3_wb_regfile_p #(.DATA_W(DW), .NREG(NR)) u_dut (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .w_control(w_control),
        .aluout(aluout), .memout(memout), .pcout(pcout), .npc(npc),
        .dr(dr), .sr1(sr1), .sr2(sr2), .d1(d1), .d2(d2),
        .psr(psr), .busy(busy), .wb_pending(wb_pending), .fsm_state(fsm_state)
    );

    lc3_wb_regfile_p #(.DATA_W(DW2), .NREG(NR2)) u_dut_wide (
        .clock(clock), .reset(reset),
        .wb_valid(w2_valid), .wb_ready(w2_ready), .w_control(w2_control),
        .aluout(w2_alu), .memout(w2_mem), .pcout(w2_pc), .npc(w2_npc),
        .dr(w2_dr), .sr1(w2_sr1), .sr2(w2_sr2), .d1(w2_d1), .d2(w2_d2),
        .psr(w2_psr), .busy(w2_busy), .wb_pending(w2_pending), .fsm_state(w2_state)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int            rd;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];      // accepted writebacks not yet in the array
    logic [DW-1:0] exp_mem [NR];
    bit            known [NR];
    logic [2:0]    exp_psr;
    int            clear_left;    // clear cycles still to run; 0 means running

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] cc_of(input logic [DW-1:0] v);
        if (v == 0)              return 3'b010;
        else if ($signed(v) < 0) return 3'b100;
        else                     return 3'b001;
    endfunction

    function automatic bit exp_read(input logic [AW-1:0] a, output logic [DW-1:0] v);
`ifdef LC3_WB_BYPASS_EN
        if (exp_q.size() > 0 && exp_q[0].rd == int'(a)) begin
            v = exp_q[0].data;
            return 1'b1;
        end
`endif
        v = exp_mem[a];
        return known[a];
    endfunction

    task automatic check_outputs();
        logic [DW-1:0] v;
        check_val("wb_ready",   32'(wb_ready),   32'(clear_left == 0));
        check_val("busy",       32'(busy),       32'(clear_left > 0));
        check_val("fsm_state",  32'(fsm_state),  32'(clear_left == 0));
        check_val("wb_pending", 32'(wb_pending), 32'(exp_q.size() > 0));
        check_val("psr",        32'(psr),        32'(exp_psr));
        if (exp_read(sr1, v)) check_val("d1", 32'(d1), 32'(v));
        if (exp_read(sr2, v)) check_val("d2", 32'(d2), 32'(v));
        if (sr1 == sr2) check_val("d1_eq_d2", 32'(d1), 32'(d2));
    endtask

    // One clock: advance the model across the edge, then compare.
    task automatic tick();
        bit            acc;
        logic [DW-1:0] src [4];
        wr_t           e;
        acc    = !reset && wb_valid && (clear_left == 0);
        src[0] = aluout; src[1] = memout; src[2] = pcout; src[3] = npc;
        @(posedge clock);
        if (reset) begin
            exp_q.delete();
            exp_psr    = 3'b010;
            clear_left = NR;
        end else begin
            if (clear_left > 0) begin
                exp_mem[NR - clear_left] = '0;
                known[NR - clear_left]   = 1'b1;
                clear_left--;
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_mem[e.rd] = e.data;
                known[e.rd]   = 1'b1;
                exp_psr       = cc_of(e.data);
            end
            if (acc) begin
                e.rd   = int'(dr);
                e.data = src[w_control];
                exp_q.push_back(e);
            end
        end
        #1;
        check_outputs();
    endtask

    // Leave reset low and count cycles until busy drops (bounded).
    task automatic wait_clear(input string tag, input int exp_len);
        int cnt;
        cnt = 0;
        while (busy && cnt < 40) begin
            tick();
            cnt++;
        end
        check_val(tag, 32'(cnt), 32'(exp_len));
    endtask

    // ---------------- driver helpers ----------------
    task automatic drive_idle();
        wb_valid = 1'b0; w_control = 2'd0;
        aluout = '0; memout = '0; pcout = '0; npc = '0;
        dr = '0; sr1 = '0; sr2 = '0;
    endtask

    task automatic drive_req(input logic [1:0] ctl, input logic [DW-1:0] val, input logic [AW-1:0] rd);
        wb_valid  = 1'b1;
        w_control = ctl;
        aluout = $urandom; memout = $urandom; pcout = $urandom; npc = $urandom;
        case (ctl)
            2'd0: aluout = val;
            2'd1: memout = val;
            2'd2: pcout  = val;
            default: npc = val;
        endcase
        dr = rd;
    endtask

    function automatic logic [DW-1:0] rand_data();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return DW'(16'h8000 | 16'($urandom));
            default: return DW'($urandom);
        endcase
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [DW-1:0] old_r5;
        for (int i = 0; i < NR; i++) known[i] = 1'b0;
        clear_left = NR;
        exp_psr    = 3'b010;
        drive_idle();
        w2_valid = 1'b0; w2_control = 2'd0;
        w2_alu = '0; w2_mem = '0; w2_pc = '0; w2_npc = '0;
        w2_dr = '0; w2_sr1 = '0; w2_sr2 = '0;

        // Reset for one cycle, then the clear sequence runs NREG cycles.
        reset = 1'b1;
        tick();
        check_val("rst_busy",  32'(busy),     32'd1);
        check_val("rst_ready", 32'(wb_ready), 32'd0);
        check_val("rst_psr",   32'(psr),      32'b010);
        reset = 1'b0;
        wait_clear("clear_len", NR);
        check_val("ready_after_clear", 32'(wb_ready), 32'd1);
        for (int i = 0; i < NR; i++) begin
            sr1 = AW'(i); sr2 = AW'(NR - 1 - i);
            tick();
            check_val("cleared_d1", 32'(d1), 32'd0);
            check_val("cleared_d2", 32'(d2), 32'd0);
        end

        // Negative result via aluout, then zero via memout.
        drive_req(2'd0, 16'h8001, 3'd3);
        tick();
        wb_valid = 1'b0; sr1 = 3'd3;
        tick();
        check_val("r3_neg", 32'(d1), 32'h8001);
        check_val("psr_n",  32'(psr), 32'b100);
        drive_req(2'd1, 16'h0000, 3'd3);
        tick();
        wb_valid = 1'b0;
        tick();
        check_val("r3_zero", 32'(d1), 32'h0);
        check_val("psr_z",   32'(psr), 32'b010);

        // Back-to-back writes to the same register; second value wins.
        drive_req(2'd3, 16'h0005, 3'd2);
        tick();
        check_val("b2b_ready0", 32'(wb_ready), 32'd1);
        drive_req(2'd2, 16'h0007, 3'd2);
        tick();
        check_val("b2b_ready1", 32'(wb_ready), 32'd1);
        check_val("b2b_pend",   32'(wb_pending), 32'd1);
        wb_valid = 1'b0; sr1 = 3'd2;
        tick();
        check_val("b2b_ready2", 32'(wb_ready), 32'd1);
        check_val("r2_second", 32'(d1), 32'h0007);
        check_val("psr_p",     32'(psr), 32'b001);

        // Read of a register whose write is still staged.
        old_r5 = exp_mem[5];
        drive_req(2'd0, 16'h1234, 3'd5);
        tick();
        wb_valid = 1'b0; sr1 = 3'd5;
        #1;
`ifdef LC3_WB_BYPASS_EN
        check_val("r5_bypass", 32'(d1), 32'h1234);
`else
        check_val("r5_old", 32'(d1), 32'(old_r5));
`endif
        tick();
        check_val("r5_new", 32'(d1), 32'h1234);

        // Reset in the middle of the clear restarts it from register 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_clear("clear_restart_len", NR);

        // Reset while a write to R1 is pending discards it.
        drive_req(2'd0, 16'h00AA, 3'd1);
        tick();
        wb_valid = 1'b0;
        tick();
        drive_req(2'd0, 16'h5555, 3'd1);
        tick();
        check_val("pend_before_rst", 32'(wb_pending), 32'd1);
        wb_valid = 1'b0; sr1 = 3'd1; reset = 1'b1;
        tick();
        check_val("r1_discarded", 32'(d1), 32'h00AA);
        reset = 1'b0;
        wait_clear("clear_after_pend_rst", NR);
        tick();
        check_val("r1_cleared", 32'(d1), 32'h0);

        // Wide build: wait for its longer clear, then write negative then zero to R15.
        for (int i = 0; i < 40 && !w2_ready; i++) tick();
        check_val("w2_ready", 32'(w2_ready), 32'd1);
        w2_valid = 1'b1; w2_control = 2'd0; w2_alu = 32'h8000_0000; w2_dr = 4'd15;
        tick();
        w2_valid = 1'b0;
        tick();
        check_val("w2_psr_n", 32'(w2_psr), 32'b100);
        w2_valid = 1'b1; w2_control = 2'd1; w2_mem = 32'h0000_0000; w2_alu = 32'hFFFF_FFFF;
        tick();
        w2_valid = 1'b0; w2_sr1 = 4'd15; w2_sr2 = 4'd15;
        tick();
        check_val("w2_psr_z", 32'(w2_psr), 32'b010);
        check_val("w2_d1",    w2_d1, 32'h0);
        check_val("w2_d2",    w2_d2, 32'h0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 149) == 0);
            wb_valid  = ($urandom_range(0, 3) != 0);
            w_control = 2'($urandom_range(0, 3));
            aluout = rand_data(); memout = rand_data();
            pcout  = rand_data(); npc    = rand_data();
            dr  = AW'($urandom_range(0, NR - 1));
            sr1 = AW'($urandom_range(0, NR - 1));
            sr2 = ($urandom_range(0, 3) == 0) ? sr1 : AW'($urandom_range(0, NR - 1));
            if ($urandom_range(0, 3) == 0 && exp_q.size() > 0) sr1 = AW'(exp_q[0].rd);
            tick();
        end
        reset = 1'b0;
        drive_idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_wb_regfile_p.md
LC3_WB_REGFILE_P -- requirements
Module: lc3_wb_regfile_p

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the data and register width (minimum 2).
REQ-002 Parameter NREG, default 8, SHALL set the register count (power of two, 2..32).
REQ-003 Localparam AW = clog2(NREG) SHALL set the register address width.
REQ-004 clock  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-006 wb_valid  input  1  SHALL indicate that a writeback request is present this cycle.
REQ-007 wb_ready  output  1  SHALL indicate that the block accepts a request this cycle.
REQ-008 w_control  input  2  SHALL select the writeback source: 0 aluout, 1 memout, 2 pcout, 3 npc.
REQ-009 aluout, memout, pcout, npc  input  DATA_W each  SHALL be the candidate writeback values.
REQ-010 dr  input  AW  SHALL be the destination register index.
REQ-011 sr1, sr2  input  AW each  SHALL be the read port addresses.
REQ-012 d1, d2  output  DATA_W each  SHALL be the read port data.
REQ-013 psr  output  3  SHALL be the condition code {N,Z,P}.
REQ-014 busy  output  1  SHALL be high while the register clear sequence is running.
REQ-015 wb_pending  output  1  SHALL be high while an accepted write is held in the stage register.

Function
REQ-016 The FSM SHALL have two states, CLEAR and RUN: CLEAR -> RUN when the clear counter reaches NREG-1; RUN -> CLEAR only on reset.
REQ-017 In CLEAR, the block SHALL write zero to register clr_cnt each cycle and increment clr_cnt, clearing all registers in exactly NREG cycles.
REQ-018 wb_ready SHALL equal (state == RUN); it SHALL have no combinational dependence on wb_valid.
REQ-019 A request SHALL be accepted on an edge where wb_valid and wb_ready are both high.
REQ-020 On acceptance, the stage register SHALL capture dr and the source value selected by w_control, and set wb_pending.
REQ-021 On the edge after acceptance, the captured data SHALL be written to the captured register and psr SHALL update: N (3'b100) if bit DATA_W-1 is set, Z (3'b010) if the value is zero, otherwise P (3'b001).
REQ-022 Accept-to-write latency SHALL be 1 cycle; back-to-back requests SHALL be accepted every cycle at full throughput.
REQ-023 wb_pending SHALL clear on the edge that performs the write, unless a new request is accepted on that same edge.
REQ-024 psr SHALL hold its value when no write is performed.
REQ-025 d1 and d2 SHALL be combinational reads of the array, indexed by sr1 and sr2.
REQ-026 When both ports address the same register, they SHALL return identical data.
REQ-027 While busy is high, d1 and d2 SHALL return the array contents (possibly not yet cleared).
REQ-028 Two consecutive writes to the same dr SHALL leave the second value in the register.

Reset
REQ-029 While reset is asserted: state <= CLEAR, clr_cnt <= 0, wb_pending <= 0, psr <= 3'b010, and busy SHALL read 1 from the first cycle after reset asserts.
REQ-030 wb_ready SHALL be 0 during and after reset until the clear sequence completes.
REQ-031 Asserting reset mid-clear SHALL restart the clear from register 0.
REQ-032 Asserting reset with wb_pending high SHALL discard the pending write, leaving the register unchanged before the clear.

Configuration
REQ-033 Macro LC3_WB_BYPASS_EN, when defined, SHALL forward the stage-register data to d1/d2 whenever wb_pending is high and sr1/sr2 equals the pending dr.
REQ-034 Without LC3_WB_BYPASS_EN, d1/d2 SHALL reflect the array only, and the new value SHALL be visible from the cycle after the write edge.

Verification
REQ-035 Reset for 1 cycle with NREG=8 -> busy high for 8 cycles, wb_ready rises on cycle 9, and all d1/d2 reads return 0.
REQ-036 Write w_control=0, aluout=16'h8001, dr=3 -> 1 cycle later R3 = 16'h8001 and psr = 3'b100; repeat with memout=0, w_control=1 -> psr = 3'b010.
REQ-037 Back-to-back writes of npc=16'h0005 (w_control=3) to dr=2, then dr=2 again with pcout=16'h0007 -> R2 = 16'h0007, psr = 3'b001, wb_ready high throughout.
REQ-038 With LC3_WB_BYPASS_EN defined: accept dr=5, aluout=16'h1234, sr1=5 in the next cycle -> d1 = 16'h1234 while wb_pending is high; without the macro -> d1 = the old R5 value in that cycle.
REQ-039 Reset asserted at clear cycle 4, and separately with wb_pending set for dr=1 -> clear restarts (8 more busy cycles) and R1 reads 0 afterwards.
REQ-040 DATA_W=32, NREG=16: write 32'h0000_0000 to dr=15 -> psr = 3'b010; sr1 = sr2 = 15 -> d1 = d2 = 0.
